// File: rtl/dclk_tx_serializer.sv
// Start-bit framed serial transmitter: one-packet holding buffer feeding an LSB-first shifter.
// Build option DCLK_TX_PARITY_EN puts even parity of the data on the pad bit (otherwise the pad is 0).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | line at 0; launches the buffered packet (start bit) when full
// ST_SHFT | W data cycles, LSB first, r_bit_cnt counts 0..W-1
// ST_PAD  | one pad cycle; frame_count increments on the edge leaving it
// ST_GAP  | GAP forced-0 cycles before the next start bit may appear

module dclk_tx_serializer #(
    parameter int    HDR_SZ   = 2,
    parameter int    PL_SZ    = 8,
    parameter int    ADDR_SZ  = 4,
    parameter int    routerid = -1,
    parameter string port     = "unknown",
    parameter int    GAP      = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              en,
    input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0]   item_in,
    input  logic                              item_valid,
    output logic                              item_ready,
    output logic                              serial_out,
    output logic                              tx_busy,
    output logic [7:0]                        frame_count
);

    localparam int W     = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam int CNT_W = $clog2(W + 1);

    if (GAP < 1 || GAP > 15 || routerid < -1) begin : g_bad_cfg
        $error("dclk_tx_serializer router %0d port %s: GAP=%0d outside 1..15", routerid, port, GAP);
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHFT,
        ST_PAD,
        ST_GAP
    } state_t;

    state_t             r_state;
    logic [W-1:0]       r_buf;
    logic               r_buf_full;
    logic [W-1:0]       r_shift;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic               r_serial;
    logic [7:0]         r_frame_cnt;

    logic               w_launch;
    logic               w_ready;
    logic               w_accept;
    logic               w_pad_bit;

    // A full buffer in IDLE is always emptied by this edge's launch, so a new
    // item can be taken on the launch edge itself and back-to-back frames
    // never lose a cycle.
    assign w_launch = en & (r_state == ST_IDLE) & r_buf_full;
    assign w_ready  = en & (~r_buf_full | (r_state == ST_IDLE));
    assign w_accept = w_ready & item_valid;

`ifdef DCLK_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_parity <= 1'b0;
        end else if (w_launch) begin
            r_parity <= ^r_buf;
        end
    end

    assign w_pad_bit = r_parity;
`else
    assign w_pad_bit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= item_in;
            r_buf_full <= 1'b1;
        end else if (w_launch) begin
            r_buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_serial    <= 1'b0;
            r_frame_cnt <= '0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_buf_full) begin
                        r_shift   <= r_buf;
                        r_serial  <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= ST_SHFT;
                    end else begin
                        r_serial  <= 1'b0;
                    end
                end
                ST_SHFT: begin
                    r_serial <= r_shift[0];
                    r_shift  <= r_shift >> 1;
                    if (r_bit_cnt == CNT_W'(W - 1)) begin
                        r_bit_cnt <= '0;
                        r_state   <= ST_PAD;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_PAD: begin
                    r_serial    <= w_pad_bit;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                    r_gap_cnt   <= '0;
                    r_state     <= ST_GAP;
                end
                ST_GAP: begin
                    r_serial <= 1'b0;
                    if (r_gap_cnt == 4'(GAP - 1)) begin
                        r_gap_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_serial <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign item_ready  = w_ready;
    assign serial_out  = r_serial;
    assign tx_busy     = (r_state != ST_IDLE);
    assign frame_count = r_frame_cnt;

endmodule

// File: tb/tb_dclk_tx_serializer.sv
// Directed bench for dclk_tx_serializer: frame timing, back-to-back, en stall, async reset, pad bit, loopback.
// Define DCLK_TX_PARITY_EN for both bench and RTL to check the parity pad build.

module tb_dclk_tx_serializer;

    localparam int HDR_SZ  = 2;
    localparam int PL_SZ   = 8;
    localparam int ADDR_SZ = 4;
    localparam int GAP     = 1;
    localparam int W       = HDR_SZ + PL_SZ + ADDR_SZ;
    localparam int N_LOOP  = 300;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          en;
    logic [W-1:0]  item_in;
    logic          item_valid;
    logic          item_ready;
    logic          serial_out;
    logic          tx_busy;
    logic [7:0]    frame_count;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            t_start;
    logic [7:0]    exp_fc;
    logic [W-1:0]  items [N_LOOP];

    dclk_tx_serializer #(
        .HDR_SZ   (HDR_SZ),
        .PL_SZ    (PL_SZ),
        .ADDR_SZ  (ADDR_SZ),
        .routerid (3),
        .port     ("east"),
        .GAP      (GAP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .item_in     (item_in),
        .item_valid  (item_valid),
        .item_ready  (item_ready),
        .serial_out  (serial_out),
        .tx_busy     (tx_busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_item(input logic [W-1:0] d);
        item_in    = d;
        item_valid = 1'b1;
        step();
        item_valid = 1'b0;
    endtask

    // Next edge must be the launch edge e0 of d's frame.
    task automatic check_frame(input logic [W-1:0] d, input int stall_bit,
                               input int stall_len, input bit b2b, input string name);
        logic exp_pad;
`ifdef DCLK_TX_PARITY_EN
        exp_pad = ^d;
`else
        exp_pad = 1'b0;
`endif
        step();
        t_start = cyc;
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL %s start bit got %b exp 1", name, serial_out);
        end
        checks++;
        if (tx_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy at start got %b exp 1", name, tx_busy);
        end
        if (b2b) begin
            checks++;
            if (item_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s ready while next waits got %b exp 0", name, item_ready);
            end
        end
        item_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            step();
            checks++;
            if (serial_out !== d[i]) begin
                errors++;
                $display("FAIL %s data bit %0d got %b exp %b", name, i, serial_out, d[i]);
            end
            if (i == stall_bit) begin
                en = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    checks++;
                    if (serial_out !== d[i] || tx_busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s stall %0d serial/busy got %b%b exp %b1",
                                 name, s, serial_out, tx_busy, d[i]);
                    end
                end
                en = 1'b1;
            end
        end
        step();
        exp_fc = exp_fc + 8'd1;
        checks++;
        if (serial_out !== exp_pad) begin
            errors++;
            $display("FAIL %s pad bit got %b exp %b", name, serial_out, exp_pad);
        end
        checks++;
        if (frame_count !== exp_fc) begin
            errors++;
            $display("FAIL %s frame_count got %0d exp %0d", name, frame_count, exp_fc);
        end
        for (int g = 0; g < GAP; g++) begin
            step();
            checks++;
            if (serial_out !== 1'b0) begin
                errors++;
                $display("FAIL %s gap %0d got %b exp 0", name, g, serial_out);
            end
        end
        checks++;
        if (tx_busy !== 1'b0 || (cyc - t_start) !== (W + 1 + GAP + stall_len)) begin
            errors++;
            $display("FAIL %s end of frame busy %b len %0d exp busy 0 len %0d",
                     name, tx_busy, cyc - t_start, W + 1 + GAP + stall_len);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        en         = 1'b1;
        item_valid = 1'b0;
        item_in    = '0;
        #3;
        checks++;
        if (serial_out !== 1'b0 || tx_busy !== 1'b0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL reset outputs serial %b busy %b fc %0d exp 0 0 0",
                     serial_out, tx_busy, frame_count);
        end
        checks++;
        if (item_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset ready en=1 got %b exp 1", item_ready);
        end
        en = 1'b0;
        #1;
        checks++;
        if (item_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset ready en=0 got %b exp 0", item_ready);
        end
        en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        exp_fc  = 8'd0;
        step();
    endtask

    task automatic test_single_frame();
        load_item(14'h2AAA);
        check_frame(14'h2AAA, -1, 0, 1'b0, "single");
        step();
        checks++;
        if (tx_busy !== 1'b0 || serial_out !== 1'b0) begin
            errors++;
            $display("FAIL single idle after frame busy %b serial %b exp 0 0", tx_busy, serial_out);
        end
    endtask

    task automatic test_back_to_back();
        int t_a;
        load_item(14'h1234);
        item_in    = 14'h0F0F;
        item_valid = 1'b1;
        check_frame(14'h1234, -1, 0, 1'b1, "b2b_A");
        t_a = t_start;
        check_frame(14'h0F0F, -1, 0, 1'b0, "b2b_B");
        checks++;
        if ((t_start - t_a) !== (W + 3)) begin
            errors++;
            $display("FAIL b2b start spacing got %0d exp %0d", t_start - t_a, W + 3);
        end
    endtask

    task automatic test_en_stall();
        load_item(14'h2C6B);
        check_frame(14'h2C6B, 3, 5, 1'b0, "stall");
    endtask

    task automatic test_async_reset();
        load_item(14'h3FFF);
        repeat (4) step();
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL areset pre-reset serial got %b exp 1", serial_out);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL areset immediate serial %b busy %b exp 0 0", serial_out, tx_busy);
        end
        #1;
        reset_n = 1'b1;
        exp_fc  = 8'd0;
        step();
        checks++;
        if (item_ready !== 1'b1 || serial_out !== 1'b0 || frame_count !== 8'd0) begin
            errors++;
            $display("FAIL areset after release ready %b serial %b fc %0d exp 1 0 0",
                     item_ready, serial_out, frame_count);
        end
        load_item(14'h2501);
        check_frame(14'h2501, -1, 0, 1'b0, "post_reset");
    endtask

    task automatic test_pad_bit();
        load_item(14'h0013);
        check_frame(14'h0013, -1, 0, 1'b0, "pad_three_ones");
        load_item(14'h0000);
        check_frame(14'h0000, -1, 0, 1'b0, "pad_zeros");
    endtask

    task automatic test_loopback();
        step();
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        for (int n = 0; n < N_LOOP; n++) items[n] = W'($urandom);
        fork
            begin
                for (int n = 0; n < N_LOOP; n++) begin
                    logic r;
                    int   guard;
                    guard      = 0;
                    item_in    = items[n];
                    item_valid = 1'b1;
                    forever begin
                        r = item_ready;
                        step();
                        if (r) break;
                        guard++;
                        if (guard > 4 * (W + 2 + GAP)) break;
                    end
                    if (!r) begin
                        checks++;
                        errors++;
                        $display("FAIL loop_drive item %0d never accepted ready %b exp 1", n, item_ready);
                        break;
                    end
                end
                item_valid = 1'b0;
            end
            begin
                logic [W-1:0] rx;
                int got;
                int budget;
                got    = 0;
                budget = 0;
                while (got < N_LOOP && budget < N_LOOP * (W + 2 + GAP) + 200) begin
                    step();
                    budget++;
                    if (serial_out === 1'b1) begin
                        rx = '0;
                        for (int b = 0; b < W; b++) begin
                            step();
                            rx[b] = serial_out;
                        end
                        step();
                        budget += W + 1;
                        checks++;
                        if (rx !== items[got]) begin
                            errors++;
                            $display("FAIL loop_rx packet %0d got %h exp %h", got, rx, items[got]);
                        end
                        got++;
                    end
                end
                if (got < N_LOOP) begin
                    checks++;
                    errors++;
                    $display("FAIL loop_rx timeout received %0d exp %0d", got, N_LOOP);
                end
            end
        join
        checks++;
        if (frame_count !== 8'd44) begin
            errors++;
            $display("FAIL loop frame_count wrap got %0d exp 44", frame_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_en_stall();
        test_async_reset();
        test_pad_bit();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
